i2s_tx: RTL and testbench

- I2S master transmitter: the playback-side counterpart of the I2S capture path.
- Derives the bit clock (sck) and word select (ws) from the system clock by integer division, in the same way as the capture-side divider.
- Serialises a stereo sample pair per frame onto sd, in standard Philips I2S format.
- Sits between the DSP/sample source and the DAC/codec pins; source feeds samples through a valid/ready handshake.

---
 rtl/i2s_pkg.sv | 15 +
 rtl/i2s_sck_gen.sv | 39 +++
 rtl/i2s_tx.sv | 136 +++++++++++++
 tb/tb_i2s_tx.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared I2S definitions: default frame format and channel encoding.
// The capture side imports this package as well.
package i2s_pkg;

    // Default frame format
    localparam int SLOT_W_DEF = 32;
    localparam int DATA_W_DEF = 24;

    // Word-select channel encoding
    typedef enum logic {
        WS_LEFT  = 1'b0,
        WS_RIGHT = 1'b1
    } ws_e;

endpackage : i2s_pkg

// File: rtl/i2s_sck_gen.sv
// I2S bit-clock generator: divides the system clock by 2*HALF_DIV.
// It also provides a one-cycle strobe on the clk edge where sck falls.
module i2s_sck_gen #(
    parameter int HALF_DIV = 32
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_sck,
    output logic o_fall
);

    localparam int                DIV_W    = (HALF_DIV > 2) ? $clog2(HALF_DIV) : 1;
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(HALF_DIV - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic             r_sck;
    logic             w_wrap;

    assign w_wrap = i_en && (r_div_cnt == DIV_LAST);

    // Half-period counter and sck toggle; disable returns both to idle at once
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_en) begin
            r_div_cnt <= '0;
            r_sck     <= 1'b0;
        end else if (w_wrap) begin
            r_div_cnt <= '0;
            r_sck     <= ~r_sck;
        end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
        end
    end

    assign o_sck  = r_sck;
    // The strobe is asserted on the same edge that drives sck from 1 to 0
    assign o_fall = w_wrap && r_sck;

endmodule : i2s_sck_gen

// File: rtl/i2s_tx.sv
// I2S master transmitter, Philips format.
// A stereo pair is taken through a one-deep holding register.
// The pair is serialised MSB first with the one-bit delay after each ws change.
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int SLOT_W   = SLOT_W_DEF,
    parameter int HALF_DIV = 32
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              en,
    input  logic [DATA_W-1:0] l_data,
    input  logic [DATA_W-1:0] r_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              sck,
    output logic              ws,
    output logic              sd,
    output logic              frame_start,
    output logic              underrun
);

    localparam int               FRAME_W  = 2 * SLOT_W;
    localparam int               CNT_W    = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] SLOT_CNT = CNT_W'(SLOT_W);

    logic                w_fall;
    logic                w_load;
    logic                w_accept;
    logic [CNT_W-1:0]    w_k;
    logic [SLOT_W-1:0]   w_l_pad;
    logic [SLOT_W-1:0]   w_r_pad;

    logic                r_hold_full;
    logic [DATA_W-1:0]   r_hold_l;
    logic [DATA_W-1:0]   r_hold_r;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [FRAME_W-1:0]  r_shreg;
    ws_e                 r_ws;
    logic                r_sd;
    logic                r_frame_start;
    logic                r_underrun;

    i2s_sck_gen #(
        .HALF_DIV (HALF_DIV)
    ) u_sck_gen (
        .i_clk  (clk_in),
        .i_rst  (rst),
        .i_en   (en),
        .o_sck  (sck),
        .o_fall (w_fall)
    );

    // Bit index of the fall being processed, wrapping at the frame length
    always_comb begin
        w_k = '0;
        if (r_bit_cnt == BIT_LAST) begin
            w_k = '0;
        end else begin
            w_k = r_bit_cnt + CNT_W'(1);
        end
    end

    // Left-justify each held sample in its slot, with zero fill below
    always_comb begin
        w_l_pad = '0;
        w_r_pad = '0;
        w_l_pad[SLOT_W-1 -: DATA_W] = r_hold_l;
        w_r_pad[SLOT_W-1 -: DATA_W] = r_hold_r;
    end

    assign w_load   = w_fall && (w_k == '0);
    assign w_accept = s_valid && !r_hold_full;

    // Holding register: an accept fills it and a frame load drains it.
    // Both cannot apply to the same pair, so a same-cycle accept is kept.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            r_hold_full <= 1'b0;
            r_hold_l    <= '0;
            r_hold_r    <= '0;
        end else if (w_accept) begin
            r_hold_full <= 1'b1;
            r_hold_l    <= l_data;
            r_hold_r    <= r_data;
        end else if (w_load) begin
            r_hold_full <= 1'b0;
        end else begin
            r_hold_full <= r_hold_full;
        end
    end

    // Serialiser: all ws/sd/bit-count updates happen on sck fall edges
    always_ff @(posedge clk_in) begin
        if (rst || !en) begin
            r_bit_cnt     <= BIT_LAST;
            r_shreg       <= '0;
            r_ws          <= WS_LEFT;
            r_sd          <= 1'b0;
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            r_underrun    <= 1'b0;
            if (w_fall) begin
                r_bit_cnt <= w_k;
                r_ws      <= (w_k >= SLOT_CNT) ? WS_RIGHT : WS_LEFT;
                // At a load this drives the final bit of the previous frame
                r_sd      <= r_shreg[FRAME_W-1];
                if (w_k == '0) begin
                    r_frame_start <= 1'b1;
                    r_underrun    <= !r_hold_full;
                    if (r_hold_full) begin
                        r_shreg <= {w_l_pad, w_r_pad};
                    end else begin
                        r_shreg <= '0;
                    end
                end else begin
                    r_shreg <= r_shreg << 1;
                end
            end else begin
                r_bit_cnt <= r_bit_cnt;
            end
        end
    end

    assign s_ready     = !r_hold_full;
    assign ws          = r_ws;
    assign sd          = r_sd;
    assign frame_start = r_frame_start;
    assign underrun    = r_underrun;

endmodule : i2s_tx

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx.
// Two instances share the stimulus: one uses 32-bit slots and one uses 24-bit slots.
// Expected pins are derived from the enabled-cycle count using frame arithmetic.
module tb_i2s_tx;

    localparam int H = 4;

    logic        clk_in = 1'b0;
    logic        rst, en, s_valid;
    logic [23:0] l_data, r_data;
    logic [1:0]  s_ready_w, sck_w, ws_w, sd_w, fs_w, ur_w;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk_in = ~clk_in;

    i2s_tx #(.DATA_W(24), .SLOT_W(32), .HALF_DIV(H)) u_dut32 (
        .clk_in(clk_in), .rst(rst), .en(en), .l_data(l_data), .r_data(r_data),
        .s_valid(s_valid), .s_ready(s_ready_w[0]), .sck(sck_w[0]), .ws(ws_w[0]),
        .sd(sd_w[0]), .frame_start(fs_w[0]), .underrun(ur_w[0]));

    i2s_tx #(.DATA_W(24), .SLOT_W(24), .HALF_DIV(H)) u_dut24 (
        .clk_in(clk_in), .rst(rst), .en(en), .l_data(l_data), .r_data(r_data),
        .s_valid(s_valid), .s_ready(s_ready_w[1]), .sck(sck_w[1]), .ws(ws_w[1]),
        .sd(sd_w[1]), .frame_start(fs_w[1]), .underrun(ur_w[1]));

    // Reference state per instance
    int          slot_w [2] = '{32, 24};
    int          m_t    [2];   // enabled clk edges since enable or reset
    bit          m_full [2];
    logic [23:0] m_hl   [2];
    logic [23:0] m_hr   [2];
    logic [63:0] m_cur  [2];   // frame currently being shifted out
    logic [63:0] m_prev [2];   // frame before it (supplies the bit at k=0)
    bit          m_fs   [2];
    bit          m_ur   [2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    function automatic logic [63:0] pack_frame(input int s, input logic [23:0] l, input logic [23:0] r);
        logic [63:0] lw, rw;
        lw = 64'(l) << (s - 24);
        rw = 64'(r) << (s - 24);
        return (lw << s) | rw;
    endfunction

    // Advance the reference by one clk edge using the inputs present at that edge
    task automatic model_step(input int i);
        bit old_full;
        int f;
        if (rst) begin
            m_t[i] = 0; m_full[i] = 1'b0; m_hl[i] = '0; m_hr[i] = '0;
            m_cur[i] = '0; m_prev[i] = '0; m_fs[i] = 1'b0; m_ur[i] = 1'b0;
            return;
        end
        old_full = m_full[i];
        m_fs[i] = 1'b0;
        m_ur[i] = 1'b0;
        if (en) begin
            m_t[i]++;
            if (m_t[i] % (2 * H) == 0) begin
                f = m_t[i] / (2 * H);
                if ((f - 1) % (2 * slot_w[i]) == 0) begin
                    m_fs[i]   = 1'b1;
                    m_ur[i]   = !old_full;
                    m_prev[i] = m_cur[i];
                    m_cur[i]  = old_full ? pack_frame(slot_w[i], m_hl[i], m_hr[i]) : 64'd0;
                    if (old_full) m_full[i] = 1'b0;
                end
            end
        end else begin
            m_t[i] = 0; m_cur[i] = '0; m_prev[i] = '0;
        end
        if (s_valid && !old_full) begin
            m_full[i] = 1'b1; m_hl[i] = l_data; m_hr[i] = r_data;
        end
    endtask

    task automatic check_outputs(input int i);
        int   f, k, s;
        logic e_sck, e_ws, e_sd;
        s     = slot_w[i];
        f     = m_t[i] / (2 * H);
        e_sck = ((m_t[i] / H) % 2) == 1;
        if (f == 0) begin
            e_ws = 1'b0; e_sd = 1'b0;
        end else begin
            k    = (f - 1) % (2 * s);
            e_ws = (k >= s);
            e_sd = (k == 0) ? m_prev[i][0] : m_cur[i][2 * s - k];
        end
        check_val($sformatf("dut%0d sck", slot_w[i]), 32'(sck_w[i]), 32'(e_sck));
        check_val($sformatf("dut%0d ws", slot_w[i]), 32'(ws_w[i]), 32'(e_ws));
        check_val($sformatf("dut%0d sd", slot_w[i]), 32'(sd_w[i]), 32'(e_sd));
        check_val($sformatf("dut%0d frame_start", slot_w[i]), 32'(fs_w[i]), 32'(m_fs[i]));
        check_val($sformatf("dut%0d underrun", slot_w[i]), 32'(ur_w[i]), 32'(m_ur[i]));
        check_val($sformatf("dut%0d s_ready", slot_w[i]), 32'(s_ready_w[i]), 32'(!m_full[i]));
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
        for (int i = 0; i < 2; i++) begin
            model_step(i);
            check_outputs(i);
        end
        @(negedge clk_in);
    endtask

    task automatic run(input int n, input int valid_pct);
        for (int c = 0; c < n; c++) begin
            s_valid = ($urandom_range(99) < valid_pct);
            l_data  = 24'($urandom);
            r_data  = 24'($urandom);
            tick();
        end
        s_valid = 1'b0;
    endtask

    task automatic load_pair(input logic [23:0] l, input logic [23:0] r);
        s_valid = 1'b1; l_data = l; r_data = r;
        tick();
        s_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; s_valid = 1'b0; l_data = '0; r_data = '0;
        // Reset values
        for (int c = 0; c < 3; c++) tick();
        rst = 1'b0;
        tick();

        // Idle transmitter with no samples: underrun at every load
        en = 1'b1;
        run(1100, 0);

        // Preloaded pair, then enable
        en = 1'b0;
        tick();
        load_pair(24'hA5A5A5, 24'h3C3C3C);
        en = 1'b1;
        run(1100, 0);

        // Last-bit-at-load boundary; the 24-bit slot instance sees it at k=0
        en = 1'b0;
        tick();
        load_pair(24'h800001, 24'h000001);
        en = 1'b1;
        run(300, 0);
        load_pair(24'h123456, 24'h000001);
        run(900, 0);

        // Continuous stream and random-valid stream
        run(2600, 100);
        run(2000, 40);

        // Enable dropouts at random points, with a held sample across them
        for (int rep = 0; rep < 6; rep++) begin
            run($urandom_range(700, 40), 50);
            en = 1'b0;
            if ($urandom_range(1) == 1) load_pair(24'($urandom), 24'($urandom));
            run($urandom_range(12, 1), 0);
            en = 1'b1;
            run(1100, 0);
        end

        // Reset mid-frame while holding a pair
        run(150, 0);
        load_pair(24'hFEDCBA, 24'h987654);
        run($urandom_range(80, 5), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run(1100, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_i2s_tx
